// File: rtl/controlador_combinacao_botoes.sv
// Button-combination decoder: sync + debounce per button, window-based grouping, one-hot output.
// Define COMBINACAO_RETENCAO_EN to hold the last combination through IDLE (default: level mode).
module controlador_combinacao_botoes #(
  parameter int N_BOTOES        = 2,
  parameter int DEBOUNCE_CICLOS = 250000,
  parameter int JANELA_CICLOS   = 2500000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BOTOES-1:0]       b_in,
  output logic [2**N_BOTOES-2:0]    estado,
  output logic [N_BOTOES-1:0]       mascara,
  output logic                      evento,
  output logic                      ocupado
);

  localparam int NE = 2**N_BOTOES - 1;
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int JW = $clog2(JANELA_CICLOS + 1);
  localparam logic [CW-1:0] DB_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [JW-1:0] JN_FIM = JW'(JANELA_CICLOS - 1);

`ifdef COMBINACAO_RETENCAO_EN
  localparam bit RETENCAO = 1'b1;
`else
  localparam bit RETENCAO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COLETA, FIXO} fsm_t;

  logic [N_BOTOES-1:0] sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [CW-1:0]       db_cnt_q [N_BOTOES];
  logic [CW-1:0]       db_cnt_d [N_BOTOES];
  fsm_t                fsm_q, fsm_d;
  logic [N_BOTOES-1:0] acc_q, acc_d, mascara_q, mascara_d, comb_nova;
  logic [JW-1:0]       cnt_q, cnt_d;
  logic [NE-1:0]       estado_q, estado_d;
  logic                evento_q, evento_d, ocupado_q, ocupado_d;

  function automatic logic [NE-1:0] um_quente(input logic [N_BOTOES-1:0] m);
    logic [NE-1:0] r;
    for (int i = 0; i < NE; i++) r[i] = (m == N_BOTOES'(i + 1));
    return r;
  endfunction

  always_comb begin
    sync1_d  = b_in;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_FIM) begin
        db_cnt_d[i] = '0;
        db_d[i]     = ~db_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    comb_nova = acc_q | db_q;
    fsm_d     = fsm_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    estado_d  = estado_q;
    mascara_d = mascara_q;
    evento_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (!RETENCAO) begin
          estado_d  = '0;
          mascara_d = '0;
        end
        if (db_q != '0) begin
          fsm_d = COLETA;
          acc_d = db_q;
          cnt_d = '0;
        end
      end
      COLETA: begin
        acc_d = comb_nova;
        cnt_d = cnt_q + JW'(1);
        // window expiry or full release both close the collection
        if (cnt_q == JN_FIM || db_q == '0) begin
          mascara_d = comb_nova;
          estado_d  = um_quente(comb_nova);
          evento_d  = 1'b1;
          fsm_d     = (db_q != '0) ? FIXO : IDLE;
        end
      end
      FIXO: begin
        if (db_q == '0) begin
          fsm_d = IDLE;
          if (!RETENCAO) begin
            estado_d  = '0;
            mascara_d = '0;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    ocupado_d = (fsm_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      for (int i = 0; i < N_BOTOES; i++) db_cnt_q[i] <= '0;
      fsm_q     <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      estado_q  <= '0;
      mascara_q <= '0;
      evento_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      fsm_q     <= fsm_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      estado_q  <= estado_d;
      mascara_q <= mascara_d;
      evento_q  <= evento_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign estado  = estado_q;
  assign mascara = mascara_q;
  assign evento  = evento_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_controlador_combinacao_botoes.sv
// Scoreboard bench: stimulus pushes expected commits, a negedge monitor checks each evento.
module tb_controlador_combinacao_botoes;

`ifdef COMBINACAO_RETENCAO_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] b_in;
  logic [2:0] estado;
  logic [1:0] mascara;
  logic       evento, ocupado;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [2:0] est;
    logic [1:0] msk;
  } exp_t;
  exp_t q[$];

  controlador_combinacao_botoes #(
    .N_BOTOES(2), .DEBOUNCE_CICLOS(4), .JANELA_CICLOS(8)
  ) dut (
    .clk(clk), .rst(rst), .b_in(b_in),
    .estado(estado), .mascara(mascara), .evento(evento), .ocupado(ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic ate(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [2:0] e, input logic [1:0] m);
    exp_t x;
    x.c = c; x.est = e; x.msk = m;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (evento === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evento at cycle %0d: estado %0h mascara %0h", cyc, estado, mascara);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("evento_cycle", 32'(cyc), 32'(x.c));
        chk("evento_estado", 32'(estado), 32'(x.est));
        chk("evento_mascara", 32'(mascara), 32'(x.msk));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    b_in = 2'b00;
    ate(4);
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_mascara", 32'(mascara), 32'd0);
    chk("rst_evento", 32'(evento), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    ate(5); rst = 1'b0;

    // b1 alone, held past the window
    ate(10); b_in = 2'b01; push(25, 3'b001, 2'b01);
    ate(16); chk("a_ocupado_pre", 32'(ocupado), 32'd0);
    ate(17); chk("a_ocupado_rise", 32'(ocupado), 32'd1);
    ate(30); chk("a_fixo_estado", 32'(estado), 32'd1);
    chk("a_fixo_mascara", 32'(mascara), 32'd1);
    ate(40); b_in = 2'b00;
    ate(46); chk("a_ocupado_hold", 32'(ocupado), 32'd1);
    ate(47); chk("a_ocupado_fall", 32'(ocupado), 32'd0);
    chk("a_estado_after", 32'(estado), HOLD ? 32'd1 : 32'd0);

    // b1 then b2 three cycles later
    ate(60); b_in = 2'b01; push(75, 3'b100, 2'b11);
    ate(63); b_in = 2'b11;
    ate(90); b_in = 2'b00;

    // short tap: early-release commit
    ate(110); b_in = 2'b01; push(123, 3'b001, 2'b01);
    ate(116); b_in = 2'b00;
    ate(124); chk("c_estado_after", 32'(estado), HOLD ? 32'd1 : 32'd0);
    chk("c_ocupado_after", 32'(ocupado), 32'd0);

    // bouncing b2, then held
    for (int k = 0; k < 10; k++) begin
      ate(140 + 2 * k);
      b_in = (k % 2 == 0) ? 2'b10 : 2'b00;
    end
    ate(160); b_in = 2'b10; push(175, 3'b010, 2'b10);
    ate(174); chk("d_ocupado", 32'(ocupado), 32'd1);
    ate(190); b_in = 2'b00;

    // FIXO ignores new presses
    ate(210); b_in = 2'b01; push(225, 3'b001, 2'b01);
    ate(230); b_in = 2'b11;
    ate(240); chk("e_fixo_estado", 32'(estado), 32'd1);
    chk("e_fixo_mascara", 32'(mascara), 32'd1);
    b_in = 2'b00;
    ate(247); chk("e_ocupado_fall", 32'(ocupado), 32'd0);
    ate(250); b_in = 2'b10; push(265, 3'b010, 2'b10);
    ate(270); b_in = 2'b00;

    // reset mid-COLETA aborts without evento
    ate(290); b_in = 2'b01;
    ate(300); chk("f_pre_rst_ocupado", 32'(ocupado), 32'd1);
    chk("f_pre_rst_estado", 32'(estado), HOLD ? 32'd2 : 32'd0);
    rst = 1'b1;
    ate(302); chk("f_rst_ocupado", 32'(ocupado), 32'd0);
    chk("f_rst_estado", 32'(estado), 32'd0);
    chk("f_rst_mascara", 32'(mascara), 32'd0);
    ate(305); rst = 1'b0; push(320, 3'b001, 2'b01);
    ate(310); chk("f_ocupado_post", 32'(ocupado), 32'd0);
    ate(330); b_in = 2'b00;
    ate(340); chk("f_estado_idle", 32'(estado), HOLD ? 32'd1 : 32'd0);
    ate(345); rst = 1'b1;
    ate(348); rst = 1'b0;
    chk("f_estado_cleared", 32'(estado), 32'd0);
    chk("f_mascara_cleared", 32'(mascara), 32'd0);

    ate(360);
    chk("pending_events", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
